// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC/IR registers plus a three-state fetch FSM with an ack timeout.
// Optional macro IFETCH_ADEL_EN rejects misaligned nPC loads with an adel pulse instead of truncating.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          TMO_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nPC,
  input  logic        PCWr,
  input  logic        IRWr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_tmo,
  output logic        adel
);

  // state | meaning
  // IDLE  | no fetch outstanding, PC writable
  // REQ   | imem_req asserted at PC, waiting for imem_ack
  // DONE  | IR just loaded, ir_valid high for this cycle
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [3:0] TMO_LAST = 4'(TMO_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        adel_q, adel_d;
  logic        pc_accept;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
    adel_d    = 1'b0;
    pc_accept = PCWr && (state_q == IDLE);

`ifdef IFETCH_ADEL_EN
    if (pc_accept) begin
      if (nPC[1:0] != 2'b00) adel_d = 1'b1;
      else                   pc_d   = nPC;
    end
`else
    if (pc_accept) pc_d = nPC & ~32'h3;
`endif

    case (state_q)
      IDLE: begin
        if (IRWr) begin
          state_d = REQ;
          cnt_d   = 4'd0;
        end
      end
      REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      cnt_q   <= 4'd0;
      tmo_q   <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      adel_q  <= adel_d;
    end
  end

  assign PC         = pc_q;
  assign IR         = ir_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == REQ);
  assign ir_valid   = (state_q == DONE);
  assign fetch_busy = (state_q != IDLE);
  assign fetch_tmo  = tmo_q;
  assign adel       = adel_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: fetch outcomes are queued at issue time and
// checked by an independent monitor; PC/IR/adel are checked against a transaction-level model.
module tb_ifetch_unit;
  localparam int          TMO   = 15;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nPC;
  logic        PCWr, IRWr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] PC, IR, imem_addr;
  logic        imem_req, ir_valid, fetch_busy, fetch_tmo, adel;

  ifetch_unit #(.RESET_PC(RST_PC), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .nPC(nPC), .PCWr(PCWr), .IRWr(IRWr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .PC(PC), .IR(IR),
    .imem_req(imem_req), .imem_addr(imem_addr), .ir_valid(ir_valid),
    .fetch_busy(fetch_busy), .fetch_tmo(fetch_tmo), .adel(adel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_tmo;
    logic [31:0] ir;
    logic [31:0] pc;
    int          req_cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc, m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Accepted PCWr seen as a plain address-load rule.
  function automatic bit model_pcwr(input logic [31:0] npc);
    logic [1:0] lo;
    lo = npc[1:0];
`ifdef IFETCH_ADEL_EN
    if (lo != 2'b00) return 1'b1;
    m_pc = npc;
    return 1'b0;
`else
    m_pc = npc - 32'(lo);
    return 1'b0;
`endif
  endfunction

  // Monitor: counts request cycles and pops one expectation per ir_valid / fetch_tmo pulse.
  int req_cnt  = 0;
  bit addr_bad = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      req_cnt  = 0;
      addr_bad = 1'b0;
    end else begin
      if (imem_req) begin
        req_cnt++;
        if (sb.size() > 0 && imem_addr !== sb[0].pc) addr_bad = 1'b1;
      end
      if (ir_valid || fetch_tmo) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {30'b0, ir_valid, fetch_tmo}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("tmo_kind", 32'(fetch_tmo), 32'(e.is_tmo));
          check("valid_kind", 32'(ir_valid), 32'(!e.is_tmo));
          check("ir_at_event", IR, e.ir);
          check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          check("req_addr_ok", 32'(addr_bad), 32'h0);
          check("busy_at_event", 32'(fetch_busy), 32'(!e.is_tmo));
        end
        req_cnt  = 0;
        addr_bad = 1'b0;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic idle_pcwr(input logic [31:0] npc);
    bit ae;
    PCWr = 1'b1;
    nPC  = npc;
    ae   = model_pcwr(npc);
    @(negedge clk);
    PCWr = 1'b0;
    check("pc_after_pcwr", PC, m_pc);
    check("adel_after_pcwr", 32'(adel), 32'(ae));
  endtask

  // lat = REQ cycle in which ack arrives; lat > TMO means the fetch times out.
  task automatic fetch(input int lat, input logic [31:0] data, input bit with_pcwr,
                       input logic [31:0] npc);
    bit   ae;
    exp_t e;
    ae = 1'b0;
    if (with_pcwr) begin
      PCWr = 1'b1;
      nPC  = npc;
      ae   = model_pcwr(npc);
    end
    IRWr         = 1'b1;
    e.is_tmo     = (lat > TMO);
    e.ir         = e.is_tmo ? m_ir : data;
    e.pc         = m_pc;
    e.req_cycles = e.is_tmo ? TMO : lat;
    sb.push_back(e);
    for (int i = 1; i <= e.req_cycles; i++) begin
      @(negedge clk);
      if (i == 1 && with_pcwr) check("adel_on_start", 32'(adel), 32'(ae));
      check("pc_hold_busy", PC, m_pc);
      IRWr       = 1'(($urandom_range(0, 1)));
      PCWr       = (i == 1) ? 1'b1 : 1'(($urandom_range(0, 1)));
      nPC        = (i == 1) ? 32'h0000_4000 : $urandom;
      imem_ack   = (i == lat);
      imem_rdata = (i == lat) ? data : $urandom;
    end
    @(negedge clk);
    if (!e.is_tmo) m_ir = data;
    if (e.is_tmo) begin
      IRWr       = 1'b0;
      PCWr       = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
    end else begin
      IRWr       = 1'(($urandom_range(0, 1)));
      PCWr       = 1'(($urandom_range(0, 1)));
      nPC        = $urandom;
      imem_ack   = 1'(($urandom_range(0, 1)));
      imem_rdata = $urandom;
    end
    @(negedge clk);
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    imem_ack = 1'b0;
    check("pc_after_fetch", PC, m_pc);
    check("ir_after_fetch", IR, m_ir);
    check("busy_after_fetch", 32'(fetch_busy), 32'h0);
    check("adel_after_fetch", 32'(adel), 32'h0);
  endtask

  initial begin
    reset = 1'b1; nPC = 32'h0; PCWr = 1'b0; IRWr = 1'b0;
    imem_rdata = 32'h0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", PC, RST_PC);
    check("rst_ir", IR, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'h0);
    check("rst_flags", {29'b0, ir_valid, fetch_tmo, adel}, 32'h0);
    reset = 1'b0;
    m_pc  = RST_PC;
    m_ir  = 32'h0;

    fetch(3, 32'h2408_0005, 1'b0, 32'h0);
    idle_pcwr(32'h0000_3004);
    fetch(2, 32'hdead_beef, 1'b0, 32'h0);
    fetch(TMO + 2, 32'h1234_5678, 1'b0, 32'h0);
    idle_pcwr(32'h0000_3006);
    fetch(1, 32'h0bad_f00d, 1'b1, 32'h0000_5008);
    fetch(TMO, 32'h5555_aaaa, 1'b1, 32'h0000_600b);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) idle_pcwr($urandom);
      fetch(int'($urandom_range(1, TMO + 2)), $urandom, 1'(($urandom_range(0, 1))), $urandom);
    end

    // Reset two cycles into a fetch; the following ack must be ignored.
    IRWr = 1'b1;
    @(negedge clk);
    IRWr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hcafe_0001;
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_ir", IR, 32'h0);
    check("midrst_pc", PC, RST_PC);
    @(negedge clk);
    imem_ack = 1'b0;
    check("midrst_ir_after_ack", IR, 32'h0);
    check("midrst_valid", 32'(ir_valid), 32'h0);
    check("midrst_busy", 32'(fetch_busy), 32'h0);
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
